bus_loader: RTL and testbench

//  Byte-stream command engine that initiates word reads/writes on the core's data-memory port
//  (address / write_value / write_sections / read_value). Lets a host load and inspect memory and

---
 rtl/bus_loader.sv | 193 +++++++++++++++++++
 tb/tb_bus_loader.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_loader.sv
// Byte-stream command engine: decodes write/read commands from a byte link and
// drives word accesses on the core's data-memory port, returning ACK/NAK/read data.
module bus_loader #(
  parameter int unsigned TIMEOUT_CYCLES = 24000000,
  parameter logic [7:0]  OP_WRITE       = 8'h57,
  parameter logic [7:0]  OP_READ        = 8'h52,
  parameter logic [7:0]  ACK            = 8'h06,
  parameter logic [7:0]  NAK            = 8'h15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready,
  output logic        bus_request,
  output logic [31:0] memory_address,
  output logic [31:0] memory_write_value,
  output logic [2:0]  memory_write_sections,
  input  logic [31:0] memory_read_value
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_WR, S_RD_ISSUE, S_RD_WAIT, S_RESP
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d, tcnt_inc;
  logic          is_write_q, is_write_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic [23:0]   resp_q, resp_d;
  logic          in_ready_d, out_valid_d, bus_request_d;
  logic [7:0]    out_data_d;
  logic [31:0]   mem_addr_d, mem_wval_d;
  logic [2:0]    mem_sec_d;
  logic          in_acc, out_acc;

  // Next-state and next-output decode; every output is registered from these.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    tcnt_d        = '0;
    is_write_d    = is_write_q;
    addr_d        = addr_q;
    data_d        = data_q;
    resp_d        = resp_q;
    out_valid_d   = out_valid;
    out_data_d    = out_data;
    bus_request_d = bus_request;
    mem_addr_d    = memory_address;
    mem_wval_d    = memory_write_value;
    mem_sec_d     = 3'b000;
    in_acc        = in_valid && in_ready;
    out_acc       = out_valid && out_ready;
    tcnt_inc      = (tcnt_q == TW'(TIMEOUT_CYCLES)) ? tcnt_q : tcnt_q + TW'(1);

    unique case (state_q)
      S_IDLE: begin
        if (in_acc) begin
          if (in_data == OP_WRITE || in_data == OP_READ) begin
            state_d    = S_ADDR;
            cnt_d      = 2'd0;
            is_write_d = (in_data == OP_WRITE);
          end else begin
            state_d     = S_RESP;
            cnt_d       = 2'd0;
            out_valid_d = 1'b1;
            out_data_d  = NAK;
          end
        end
      end
      S_ADDR: begin
        if (in_acc) begin
          addr_d[{cnt_q, 3'b000} +: 8] = in_data;
          bus_request_d = 1'b1;
          cnt_d         = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            if (addr_d[1:0] != 2'b00) begin
              state_d     = S_RESP;
              cnt_d       = 2'd0;
              out_valid_d = 1'b1;
              out_data_d  = NAK;
            end else if (is_write_q) begin
              state_d = S_DATA;
            end else begin
              state_d    = S_RD_ISSUE;
              mem_addr_d = addr_d & 32'hFFFF_FFFC;
            end
          end
        end else begin
          tcnt_d = tcnt_inc;
          if (tcnt_inc == TW'(TIMEOUT_CYCLES)) begin
            state_d       = S_IDLE;
            bus_request_d = 1'b0;
            tcnt_d        = '0;
          end
        end
      end
      S_DATA: begin
        if (in_acc) begin
          data_d[{cnt_q, 3'b000} +: 8] = in_data;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d    = S_WR;
            mem_addr_d = addr_q & 32'hFFFF_FFFC;
            mem_wval_d = data_d;
            mem_sec_d  = 3'b111;
          end
        end else begin
          tcnt_d = tcnt_inc;
          if (tcnt_inc == TW'(TIMEOUT_CYCLES)) begin
            state_d       = S_IDLE;
            bus_request_d = 1'b0;
            tcnt_d        = '0;
          end
        end
      end
      S_WR: begin
        state_d     = S_RESP;
        cnt_d       = 2'd0;
        out_valid_d = 1'b1;
        out_data_d  = ACK;
      end
      S_RD_ISSUE: state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        state_d     = S_RESP;
        cnt_d       = 2'd3;
        resp_d      = memory_read_value[31:8];
        out_valid_d = 1'b1;
        out_data_d  = memory_read_value[7:0];
      end
      S_RESP: begin
        // cnt_q counts the bytes still queued behind the one on out_data
        if (out_acc) begin
          if (cnt_q == 2'd0) begin
            state_d       = S_IDLE;
            out_valid_d   = 1'b0;
            bus_request_d = 1'b0;
          end else begin
            cnt_d      = cnt_q - 2'd1;
            out_data_d = resp_q[7:0];
            resp_d     = {8'h00, resp_q[23:8]};
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d = (state_d == S_IDLE) || (state_d == S_ADDR) || (state_d == S_DATA);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q               <= S_IDLE;
      cnt_q                 <= '0;
      tcnt_q                <= '0;
      is_write_q            <= 1'b0;
      addr_q                <= '0;
      data_q                <= '0;
      resp_q                <= '0;
      in_ready              <= 1'b0;
      out_valid             <= 1'b0;
      out_data              <= '0;
      bus_request           <= 1'b0;
      memory_address        <= '0;
      memory_write_value    <= '0;
      memory_write_sections <= '0;
    end else begin
      state_q               <= state_d;
      cnt_q                 <= cnt_d;
      tcnt_q                <= tcnt_d;
      is_write_q            <= is_write_d;
      addr_q                <= addr_d;
      data_q                <= data_d;
      resp_q                <= resp_d;
      in_ready              <= in_ready_d;
      out_valid             <= out_valid_d;
      out_data              <= out_data_d;
      bus_request           <= bus_request_d;
      memory_address        <= mem_addr_d;
      memory_write_value    <= mem_wval_d;
      memory_write_sections <= mem_sec_d;
    end
  end

endmodule

// File: tb/tb_bus_loader.sv
// Bench for bus_loader: directed scenarios plus random commands, checked against a
// command-level reference model and a word-addressed memory model.
module tb_bus_loader;

  localparam int unsigned TO = 8;
  localparam logic [7:0] OPW = 8'h57, OPR = 8'h52, ACKB = 8'h06, NAKB = 8'h15;

  typedef logic [7:0] bq_t [$];

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic        bus_request;
  logic [31:0] memory_address;
  logic [31:0] memory_write_value;
  logic [2:0]  memory_write_sections;
  logic [31:0] memory_read_value;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ready_mode = 0;
  int wr_count = 0, wr_cyc = 0, last_in_cyc = 0, ov_rise_cyc = 0;
  logic [31:0] wr_addr, wr_val, wtmp;
  logic [2:0]  wr_sec;
  logic        prev_ov = 1'b0, prev_ordy = 1'b0;
  logic [7:0]  prev_od = 8'h00;
  bq_t         got;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  bus_loader #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .bus_request(bus_request), .memory_address(memory_address),
    .memory_write_value(memory_write_value), .memory_write_sections(memory_write_sections),
    .memory_read_value(memory_read_value)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory port model: sectioned word writes, one-cycle registered read.
  always @(posedge clk) begin
    if (memory_write_sections != 3'b000) begin
      wtmp = mem.exists(memory_address) ? mem[memory_address] : 32'h0;
      if (memory_write_sections[0]) wtmp[7:0]   = memory_write_value[7:0];
      if (memory_write_sections[1]) wtmp[15:8]  = memory_write_value[15:8];
      if (memory_write_sections[2]) wtmp[31:16] = memory_write_value[31:16];
      mem[memory_address] = wtmp;
    end
    memory_read_value <= mem.exists(memory_address) ? mem[memory_address] : 32'h0;
  end

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor between edges: collect transfers and bus writes, check response hold rules.
  always @(negedge clk) begin
    if (!reset) begin
      if (in_valid && in_ready) last_in_cyc = cyc;
      if (out_valid && out_ready) got.push_back(out_data);
      if (out_valid && !prev_ov) ov_rise_cyc = cyc;
      if (memory_write_sections != 3'b000) begin
        wr_count++;
        wr_cyc  = cyc;
        wr_addr = memory_address;
        wr_val  = memory_write_value;
        wr_sec  = memory_write_sections;
      end
      if (out_valid) check("in_ready_low_in_resp", 32'(in_ready), 32'h0);
      if (prev_ov && !prev_ordy) begin
        check("hold_valid", 32'(out_valid), 32'h1);
        check("hold_data", 32'(out_data), 32'(prev_od));
      end
      prev_ov = out_valid;
    end else begin
      prev_ov = 1'b0;
    end
    prev_ordy = out_ready;
    prev_od   = out_data;
  end

  // Reference model: expected response bytes of one complete command.
  task automatic model_cmd(input logic [7:0] op, input logic [31:0] addr,
                           input logic [31:0] data, output bq_t rsp);
    logic [31:0] v;
    rsp = {};
    if (op != OPW && op != OPR) rsp.push_back(NAKB);
    else if (addr[1:0] != 2'b00) rsp.push_back(NAKB);
    else if (op == OPW) begin
      ref_mem[addr] = data;
      rsp.push_back(ACKB);
    end else begin
      v = ref_mem.exists(addr) ? ref_mem[addr] : 32'h0;
      for (int i = 0; i < 4; i++) rsp.push_back(v[8*i +: 8]);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        check("in_ready_timeout", 32'(in_ready), 32'h1);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [31:0] addr,
                            input logic [31:0] data, input int gap);
    send_byte(op, gap);
    if (op == OPW || op == OPR) begin
      for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8], gap);
      if (op == OPW && addr[1:0] == 2'b00)
        for (int i = 0; i < 4; i++) send_byte(data[8*i +: 8], gap);
    end
  endtask

  task automatic wait_resp(input bq_t exp, input string tag);
    int n;
    n = 0;
    while (got.size() < exp.size() && n < 400) begin
      @(posedge clk); #2;
      n++;
    end
    repeat (3) @(posedge clk);
    #2;
    check({tag, "_len"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), 32'(got[i]), 32'(exp[i]));
    check({tag, "_bus_request_low"}, 32'(bus_request), 32'h0);
    got.delete();
  endtask

  task automatic run_cmd(input logic [7:0] op, input logic [31:0] addr,
                         input logic [31:0] data, input int gap, input string tag);
    bq_t exp;
    send_frame(op, addr, data, gap);
    model_cmd(op, addr, data, exp);
    wait_resp(exp, tag);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'h0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'h0);
    check({tag, "_out_data"}, 32'(out_data), 32'h0);
    check({tag, "_bus_request"}, 32'(bus_request), 32'h0);
    check({tag, "_address"}, memory_address, 32'h0);
    check({tag, "_write_value"}, memory_write_value, 32'h0);
    check({tag, "_sections"}, 32'(memory_write_sections), 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t exp;
    int w0, n;
    logic [7:0] op;
    logic [31:0] a, d;

    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;
    @(posedge clk); #1;
    check("idle_in_ready", 32'(in_ready), 32'h1);

    // Word write with one WR cycle one clock after the last data byte.
    w0 = wr_count;
    run_cmd(OPW, 32'h10, 32'hDEADBEEF, 0, "write");
    check("write_count", 32'(wr_count - w0), 32'h1);
    check("write_addr", wr_addr, 32'h10);
    check("write_value", wr_val, 32'hDEADBEEF);
    check("write_sections", 32'(wr_sec), 32'h7);
    check("write_latency", 32'(wr_cyc - last_in_cyc), 32'h1);

    // Read of a preloaded word, first response byte three clocks after the last address byte.
    mem[32'h10] = 32'h12345678;
    ref_mem[32'h10] = 32'h12345678;
    w0 = wr_count;
    run_cmd(OPR, 32'h10, 32'h0, 0, "read");
    check("read_latency", 32'(ov_rise_cyc - last_in_cyc), 32'h3);
    check("read_no_write", 32'(wr_count - w0), 32'h0);

    // Back-pressure during a read response.
    mem[32'h20] = 32'hA1B2C3D4;
    ref_mem[32'h20] = 32'hA1B2C3D4;
    ready_mode = 2;
    send_frame(OPR, 32'h20, 32'h0, 0);
    model_cmd(OPR, 32'h20, 32'h0, exp);
    n = 0;
    while (!out_valid && n < 50) begin @(posedge clk); #2; n++; end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #2;
      check("bp_valid", 32'(out_valid), 32'h1);
      check("bp_in_ready", 32'(in_ready), 32'h0);
      check("bp_no_transfer", 32'(got.size()), 32'h0);
    end
    ready_mode = 0;
    wait_resp(exp, "bp_read");

    // Misaligned write is refused without bus access.
    w0 = wr_count;
    run_cmd(OPW, 32'h11, 32'hCAFEF00D, 0, "misaligned");
    check("misaligned_no_write", 32'(wr_count - w0), 32'h0);
    run_cmd(OPR, 32'h10, 32'h0, 0, "after_nak_read");

    // Stalled command is dropped after the idle limit; a shorter gap is tolerated.
    send_byte(OPR, 0); send_byte(8'h10, 0); send_byte(8'h00, 0);
    repeat (4) @(posedge clk);
    #1;
    check("timeout_pending", 32'(bus_request), 32'h1);
    repeat (6) @(posedge clk);
    #1;
    check("timeout_bus_request", 32'(bus_request), 32'h0);
    check("timeout_in_ready", 32'(in_ready), 32'h1);
    check("timeout_no_output", 32'(got.size()), 32'h0);
    run_cmd(OPR, 32'h10, 32'h0, 0, "after_timeout");
    send_byte(OPR, 0); send_byte(8'h20, 0); send_byte(8'h00, 0);
    send_byte(8'h00, 6); send_byte(8'h00, 6);
    model_cmd(OPR, 32'h20, 32'h0, exp);
    wait_resp(exp, "slow_read");

    // Unknown opcode, then reset in the middle of a write's data phase.
    run_cmd(8'h41, 32'h0, 32'h0, 0, "bad_op");
    w0 = wr_count;
    send_byte(OPW, 0);
    for (int i = 0; i < 4; i++) send_byte(8'((32'h30 >> (8*i))), 0);
    send_byte(8'hAA, 0); send_byte(8'hBB, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    check_all_zero("mid_reset");
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    check("reset_no_output", 32'(got.size()), 32'h0);
    check("reset_no_write", 32'(wr_count - w0), 32'h0);
    run_cmd(OPW, 32'h30, 32'h0BADCAFE, 0, "post_reset_write");
    run_cmd(OPR, 32'h30, 32'h0, 0, "post_reset_read");

    // Random commands with random sink back-pressure.
    ready_mode = 1;
    for (int t = 0; t < 40; t++) begin
      n = int'($urandom_range(0, 9));
      a = 32'($urandom_range(0, 15)) << 2;
      d = $urandom;
      if (n == 0) begin
        op = 8'($urandom_range(0, 255));
        if (op == OPW || op == OPR) op = 8'h00;
      end else begin
        op = ($urandom_range(0, 1) != 0) ? OPW : OPR;
        if (n == 1) a = a | 32'($urandom_range(1, 3));
      end
      run_cmd(op, a, d, int'($urandom_range(0, 2)), $sformatf("rnd%0d", t));
    end
    ready_mode = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
